// File: rtl/shifter_pkg.sv
// ============================================================================
//  Module   : shifter_pkg
//  Purpose  : Shared op encodings, op type and stage-count helper for the
//             pipelined barrel shifter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package shifter_pkg;

    // Shift/rotate operation selector
    typedef enum logic [1:0] {
        OP_ROL = 2'b00,
        OP_SLL = 2'b01,
        OP_SRA = 2'b10,
        OP_SRL = 2'b11
    } op_t;

    // Number of shift-count bits (and pipeline stages) for a given data width
    function automatic int cnt_w(input int width);
        int n;
        n = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < width) begin
                n = i + 1;
            end
        end
        return n;
    endfunction

endpackage : shifter_pkg

`default_nettype wire

// File: rtl/shifter_stage.sv
// ============================================================================
//  Module   : shifter_stage
//  Purpose  : Combinational one-level conditional shift/rotate by SHAMT.
//             Passes data through unchanged when en_i is low.
//             With SHIFTER_FLAGS_EN, also forwards the last bit shifted out.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shifter_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHAMT = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  op_t              op_i,
    input  logic             en_i,
`ifdef SHIFTER_FLAGS_EN
    input  logic             carry_i,
    output logic             carry_o,
`endif
    output logic [WIDTH-1:0] data_o
);

    // Conditional shift by SHAMT. For SRA the current MSB is the operand's
    // original sign bit: every earlier stage refilled the top with that same
    // bit, so no separate sign register is needed.
    always_comb begin
        data_o = data_i;
`ifdef SHIFTER_FLAGS_EN
        carry_o = carry_i;
`endif
        if (en_i) begin
            case (op_i)
                OP_ROL: data_o = {data_i[WIDTH-1-SHAMT:0], data_i[WIDTH-1:WIDTH-SHAMT]};
                OP_SLL: data_o = {data_i[WIDTH-1-SHAMT:0], {SHAMT{1'b0}}};
                OP_SRA: data_o = {{SHAMT{data_i[WIDTH-1]}}, data_i[WIDTH-1:SHAMT]};
                OP_SRL: data_o = {{SHAMT{1'b0}}, data_i[WIDTH-1:SHAMT]};
                default: data_o = data_i;
            endcase
`ifdef SHIFTER_FLAGS_EN
            // A later stage shifts after an earlier one, so its last bit out
            // supersedes whatever carry arrived from upstream.
            if (op_i == OP_ROL || op_i == OP_SLL) begin
                carry_o = data_i[WIDTH-SHAMT];
            end else begin
                carry_o = data_i[SHAMT-1];
            end
`endif
        end
    end

endmodule : shifter_stage

`default_nettype wire

// File: rtl/shifter_pipe.sv
// ============================================================================
//  Module   : shifter_pipe
//  Purpose  : Parametrised pipelined barrel shifter (ROL/SLL/SRA/SRL) with
//             valid/ready handshake and global-stall backpressure. Stage k
//             shifts by 2^k when cnt[k] is set; latency is CNT_W cycles.
//             Optional macro SHIFTER_FLAGS_EN adds out_zero / out_carry.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shifter_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    input  logic [cnt_w(WIDTH)-1:0]     in_cnt,
    input  logic [1:0]                  in_op,
    output logic                        out_valid,
    input  logic                        out_ready,
`ifdef SHIFTER_FLAGS_EN
    output logic                        out_zero,
    output logic                        out_carry,
`endif
    output logic [WIDTH-1:0]            out_data
);

    localparam int CNT_W = cnt_w(WIDTH);

    // Pipeline registers: index s holds the result of stage s
    logic [WIDTH-1:0] data_q  [CNT_W];
    op_t              op_q    [CNT_W];
    logic [CNT_W-1:0] cnt_q   [CNT_W];
    logic             valid_q [CNT_W];

    // Stage inputs (stage 0 fed straight from the input port) and results
    logic [WIDTH-1:0] stg_data  [CNT_W];
    op_t              stg_op    [CNT_W];
    logic [CNT_W-1:0] stg_cnt   [CNT_W];
    logic             stg_valid [CNT_W];
    logic [WIDTH-1:0] data_d    [CNT_W];

`ifdef SHIFTER_FLAGS_EN
    logic             carry_q   [CNT_W];
    logic             stg_carry [CNT_W];
    logic             carry_d   [CNT_W];
    logic             zero_q;
`endif

    logic advance;

    // Whole pipe moves together; it only freezes when a result is stuck
    assign advance  = !out_valid | out_ready;
    assign in_ready = advance;

    // Route each stage's input from the previous register (or the port)
    always_comb begin
        stg_data[0]  = in_data;
        stg_op[0]    = op_t'(in_op);
        stg_cnt[0]   = in_cnt;
        stg_valid[0] = in_valid;
`ifdef SHIFTER_FLAGS_EN
        stg_carry[0] = 1'b0;
`endif
        for (int s = 1; s < CNT_W; s++) begin
            stg_data[s]  = data_q[s-1];
            stg_op[s]    = op_q[s-1];
            stg_cnt[s]   = cnt_q[s-1];
            stg_valid[s] = valid_q[s-1];
`ifdef SHIFTER_FLAGS_EN
            stg_carry[s] = carry_q[s-1];
`endif
        end
    end

    generate
        for (genvar s = 0; s < CNT_W; s++) begin : g_stage
            shifter_stage #(
                .WIDTH (WIDTH),
                .SHAMT (1 << s)
            ) u_stage (
                .data_i  (stg_data[s]),
                .op_i    (stg_op[s]),
                .en_i    (stg_cnt[s][s]),
`ifdef SHIFTER_FLAGS_EN
                .carry_i (stg_carry[s]),
                .carry_o (carry_d[s]),
`endif
                .data_o  (data_d[s])
            );
        end
    endgenerate

    // Pipeline registers; bubbles shift along with real data and never collapse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < CNT_W; s++) begin
                data_q[s]  <= '0;
                op_q[s]    <= OP_ROL;
                cnt_q[s]   <= '0;
                valid_q[s] <= 1'b0;
            end
        end else if (advance) begin
            for (int s = 0; s < CNT_W; s++) begin
                data_q[s]  <= data_d[s];
                op_q[s]    <= stg_op[s];
                cnt_q[s]   <= stg_cnt[s];
                valid_q[s] <= stg_valid[s];
            end
        end
    end

`ifdef SHIFTER_FLAGS_EN
    // Carry chain and zero flag, registered alongside the data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < CNT_W; s++) begin
                carry_q[s] <= 1'b0;
            end
            zero_q <= 1'b0;
        end else if (advance) begin
            for (int s = 0; s < CNT_W; s++) begin
                carry_q[s] <= carry_d[s];
            end
            zero_q <= (data_d[CNT_W-1] == '0);
        end
    end

    assign out_zero  = zero_q;
    assign out_carry = carry_q[CNT_W-1];
`endif

    assign out_data  = data_q[CNT_W-1];
    assign out_valid = valid_q[CNT_W-1];

endmodule : shifter_pipe

`default_nettype wire

// File: tb/tb_shifter_pipe.sv
// ============================================================================
//  Module   : tb_shifter_pipe
//  Purpose  : Self-checking bench for shifter_pipe (WIDTH=16): directed
//             vectors, back-to-back latency, backpressure, mid-stream reset
//             and randomized traffic against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shifter_pipe;

    localparam int W     = 16;
    localparam int CNT_W = 4;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic [CNT_W-1:0] in_cnt;
    logic [1:0]     in_op;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
`ifdef SHIFTER_FLAGS_EN
    logic           out_zero;
    logic           out_carry;
`endif

    shifter_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cnt    (in_cnt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef SHIFTER_FLAGS_EN
        .out_zero  (out_zero),
        .out_carry (out_carry),
`endif
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic         carry;
        logic         zero;
        int           acc;
    } exp_t;

    exp_t         q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc   = 0;
    bit           lat_chk  = 1'b0;
    bit           hold_chk = 1'b0;
    logic [W-1:0] held;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Behavioural model: whole shift in one step with plain operators
    function automatic exp_t model(input logic [W-1:0] d, input int n, input int op);
        exp_t e;
        logic signed [W-1:0] sd;
        sd = d;
        case (op)
            0: e.data = (n == 0) ? d : ((d << n) | (d >> (W - n)));
            1: e.data = d << n;
            2: e.data = sd >>> n;
            default: e.data = d >> n;
        endcase
        if (n == 0)       e.carry = 1'b0;
        else if (op < 2)  e.carry = d[W-n];
        else              e.carry = d[n-1];
        e.zero = (e.data == '0);
        e.acc  = 0;
        return e;
    endfunction

    // One clock: score outputs/accepts with settled inputs, then advance
    task automatic cycle();
        bit   acc, pop;
        exp_t e;
        #1;
        acc = in_valid && in_ready;
        pop = out_valid && out_ready;
        if (hold_chk) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'(out_data), 64'(held));
        end
        if (pop) begin
            chk("result_expected", 64'(q.size() > 0), 64'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("out_data", 64'(out_data), 64'(e.data));
`ifdef SHIFTER_FLAGS_EN
                chk("out_zero", 64'(out_zero), 64'(e.zero));
                chk("out_carry", 64'(out_carry), 64'(e.carry));
`endif
                if (lat_chk) chk("latency", 64'(cyc - e.acc), 64'(CNT_W));
            end
        end
        hold_chk = out_valid && !out_ready && !rst;
        held     = out_data;
        if (acc) begin
            e     = model(in_data, int'(in_cnt), int'(in_op));
            e.acc = cyc;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rnd_drive();
        in_data = W'($urandom);
        in_cnt  = CNT_W'($urandom_range(0, W - 1));
        in_op   = 2'($urandom_range(0, 3));
    endtask

    // Present one operand until accepted; expected data is the given constant
    task automatic put(input logic [W-1:0] d, input int n, input int op, input logic [W-1:0] expd);
        bit got;
        got      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_cnt   = CNT_W'(n);
        in_op    = 2'(op);
        for (int i = 0; i < 20 && !got; i++) begin
            got = in_ready;
            cycle();
        end
        chk("accept", 64'(got), 64'd1);
        if (got && q.size() > 0) q[q.size() - 1].data = expd;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && q.size() > 0; i++) cycle();
        chk("drain_empty", 64'(q.size()), 64'd0);
        chk("drain_idle", 64'(out_valid), 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_cnt    = '0;
        in_op     = '0;
        out_ready = 1'b1;

        // Reset state
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef SHIFTER_FLAGS_EN
        chk("rst_out_zero", 64'(out_zero), 64'd0);
        chk("rst_out_carry", 64'(out_carry), 64'd0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors, out_ready held high, latency checked
        lat_chk = 1'b1;
        put(16'h8001, 1, 0, 16'h0003);
        put(16'h00FF, 4, 1, 16'h0FF0);
        put(16'h8000, 15, 2, 16'hFFFF);
        put(16'h8000, 15, 3, 16'h0001);
        put(16'h8000, 1, 1, 16'h0000);
        put(16'hA5C3, 0, 0, 16'hA5C3);
        put(16'hA5C3, 0, 1, 16'hA5C3);
        put(16'hA5C3, 0, 2, 16'hA5C3);
        put(16'hA5C3, 0, 3, 16'hA5C3);
        put(16'h4000, 15, 2, 16'h0000);
        put(16'h1234, 15, 0, 16'h091A);
        drain();

        // Back-to-back: 8 random ops in consecutive cycles
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rnd_drive();
            cycle();
        end
        drain();

        // Backpressure: fill the pipe with out_ready low, hold, then release
        lat_chk   = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 20 && in_ready; i++) begin
            rnd_drive();
            cycle();
        end
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_queue", 64'(q.size()), 64'(CNT_W));
        for (int i = 0; i < 5; i++) begin
            rnd_drive();
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            cycle();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rnd_drive();
            cycle();
        end
        drain();

        // Mid-stream reset with 3 ops in flight
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rnd_drive();
            cycle();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        q.delete();
        hold_chk = 1'b0;
        #1;
        chk("rst_async_valid", 64'(out_valid), 64'd0);
        cycle();
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("post_rst_valid", 64'(out_valid), 64'd0);
            cycle();
        end
        lat_chk = 1'b1;
        put(16'h00F0, 3, 3, 16'h001E);
        drain();

        // Random traffic with random backpressure
        lat_chk = 1'b0;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rnd_drive();
            cycle();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_shifter_pipe

`default_nettype wire
